// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_param.
// The master drives requests; the slave (the FIFO) drives data and status.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  flush;
  logic                  clr_err;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, flush, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, flush, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush, sticky overflow/underflow flags and standard or FWFT read mode.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $fatal(1, "sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
    $fatal(1, "sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc_s;
  logic          rd_acc_s;

  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [ADDR_WIDTH-1:0] raddr_s;

  assign waddr_s = wptr_q[ADDR_WIDTH-1:0];
  assign raddr_s = rptr_q[ADDR_WIDTH-1:0];

  // Acceptance is judged on the registered flags only; flush suppresses both sides.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (bus.flush) begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end else begin
      wr_acc_s = bus.wr_en && !full_q;
      rd_acc_s = bus.rd_en && !empty_q;
    end
  end

  // Next-state for pointers, occupancy, status flags and sticky errors.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;

    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc_s) begin
        wptr_d = wptr_q + ONE_C;
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + ONE_C;
      end else begin
        rptr_d = rptr_q;
      end
    end

    // Pointers carry a wrap bit, so their difference is exactly the occupancy 0..DEPTH.
    count_d = wptr_d - rptr_d;
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    if (!bus.flush && bus.wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (!bus.flush && bus.rd_en && empty_q) begin
      udf_d = 1'b1;
    end else if (bus.clr_err) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control and status state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[waddr_s] <= bus.data_in;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read port: updates only on an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc_s) begin
        dout_q <= mem_q[raddr_s];
      end else begin
        dout_q <= dout_q;
      end
    end

    assign bus.data_out = dout_q;
  end else begin : g_fwft
    // Head of queue is presented directly; meaningless while empty.
    assign bus.data_out = mem_q[raddr_s];
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance
// sharing clock and reset, each scenario in its own task with inline checks.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) a_if ();
  sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) b_if ();

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
    dut_std (.clk(clk), .rst(rst), .bus(a_if));

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
    dut_fwft (.clk(clk), .rst(rst), .bus(b_if));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.flush = 1'b0; a_if.clr_err = 1'b0;
    a_if.data_in = 8'h00;
  endtask

  task automatic test_reset();
    a_idle();
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.flush = 1'b0; b_if.clr_err = 1'b0;
    b_if.data_in = 8'h00;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if ({a_if.empty, a_if.almost_empty, a_if.full, a_if.almost_full} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b want 1100",
        {a_if.empty, a_if.almost_empty, a_if.full, a_if.almost_full});
    end
    checks++;
    if (a_if.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_if.count); end
    checks++;
    if (a_if.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", a_if.data_out); end
    checks++;
    if ({a_if.overflow, a_if.underflow} !== 2'b00) begin
      errors++; $display("FAIL reset_err: got %b want 00", {a_if.overflow, a_if.underflow});
    end
    checks++;
    if ({b_if.empty, b_if.full, b_if.count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL reset_fwft: got e=%b f=%b c=%0d want e=1 f=0 c=0",
        b_if.empty, b_if.full, b_if.count);
    end
    a_if.rd_en = 1'b1;
    cyc();
    a_if.rd_en = 1'b0;
    checks++;
    if ({a_if.underflow, a_if.count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL reset_underflow: got u=%b c=%0d want u=1 c=0", a_if.underflow, a_if.count);
    end
    a_if.clr_err = 1'b1;
    cyc();
    a_if.clr_err = 1'b0;
    checks++;
    if (a_if.underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow: got %b want 0", a_if.underflow); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      a_if.wr_en = 1'b1; a_if.data_in = 8'h11 + 8'(i);
      cyc();
      checks++;
      if ({a_if.count, a_if.almost_full, a_if.full} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16)}) begin
        errors++; $display("FAIL fill_%0d: got c=%0d af=%b f=%b want c=%0d af=%b f=%b", i,
          a_if.count, a_if.almost_full, a_if.full, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    a_if.data_in = 8'hFF;
    cyc();
    a_if.wr_en = 1'b0;
    checks++;
    if ({a_if.overflow, a_if.count} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL overflow: got o=%b c=%0d want o=1 c=16", a_if.overflow, a_if.count);
    end
    for (int i = 0; i < 16; i++) begin
      a_if.rd_en = 1'b1;
      cyc();
      exp_d = 8'h11 + 8'(i);
      checks++;
      if ({a_if.data_out, a_if.count, a_if.almost_empty} !== {exp_d, 5'(15 - i), (15 - i <= 2)}) begin
        errors++; $display("FAIL drain_%0d: got d=%h c=%0d ae=%b want d=%h c=%0d ae=%b", i,
          a_if.data_out, a_if.count, a_if.almost_empty, exp_d, 15 - i, (15 - i <= 2));
      end
    end
    a_if.rd_en = 1'b0;
    checks++;
    if (a_if.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", a_if.empty); end
    a_if.clr_err = 1'b1;
    cyc();
    a_if.clr_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      a_if.wr_en = 1'b1; a_if.data_in = 8'h30 + 8'(i);
      cyc();
    end
    for (int j = 0; j < 40; j++) begin
      a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.data_in = 8'h35 + 8'(j);
      cyc();
      exp_d = 8'h30 + 8'(j);
      checks++;
      if ({a_if.count, a_if.data_out} !== {5'd5, exp_d}) begin
        errors++; $display("FAIL b2b_%0d: got c=%0d d=%h want c=5 d=%h", j, a_if.count, a_if.data_out, exp_d);
      end
    end
    a_if.wr_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      exp_d = 8'h58 + 8'(k);
      checks++;
      if ({a_if.count, a_if.data_out} !== {5'(4 - k), exp_d}) begin
        errors++; $display("FAIL b2b_tail_%0d: got c=%0d d=%h want c=%0d d=%h", k,
          a_if.count, a_if.data_out, 4 - k, exp_d);
      end
    end
    a_if.rd_en = 1'b0;
  endtask

  task automatic test_full_empty_simul();
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      a_if.wr_en = 1'b1; a_if.data_in = 8'h60 + 8'(i);
      cyc();
    end
    a_if.rd_en = 1'b1; a_if.data_in = 8'hEE;
    cyc();
    a_if.wr_en = 1'b0;
    checks++;
    if ({a_if.count, a_if.overflow, a_if.data_out} !== {5'd15, 1'b1, 8'h60}) begin
      errors++; $display("FAIL full_wr_rd: got c=%0d o=%b d=%h want c=15 o=1 d=60",
        a_if.count, a_if.overflow, a_if.data_out);
    end
    for (int k = 0; k < 15; k++) begin
      cyc();
      exp_d = 8'h61 + 8'(k);
      checks++;
      if (a_if.data_out !== exp_d) begin
        errors++; $display("FAIL full_drain_%0d: got %h want %h", k, a_if.data_out, exp_d);
      end
    end
    a_if.rd_en = 1'b0; a_if.clr_err = 1'b1;
    cyc();
    a_if.clr_err = 1'b0;
    checks++;
    if ({a_if.empty, a_if.overflow} !== 2'b10) begin
      errors++; $display("FAIL full_clr: got e=%b o=%b want e=1 o=0", a_if.empty, a_if.overflow);
    end
    a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.data_in = 8'h77;
    cyc();
    a_if.wr_en = 1'b0;
    checks++;
    if ({a_if.count, a_if.underflow, a_if.data_out} !== {5'd1, 1'b1, 8'h6F}) begin
      errors++; $display("FAIL empty_wr_rd: got c=%0d u=%b d=%h want c=1 u=1 d=6f",
        a_if.count, a_if.underflow, a_if.data_out);
    end
    cyc();
    a_if.rd_en = 1'b0;
    checks++;
    if ({a_if.count, a_if.data_out} !== {5'd0, 8'h77}) begin
      errors++; $display("FAIL empty_pop: got c=%0d d=%h want c=0 d=77", a_if.count, a_if.data_out);
    end
    a_if.clr_err = 1'b1;
    cyc();
    a_if.clr_err = 1'b0;
  endtask

  task automatic test_fwft();
    b_if.wr_en = 1'b1; b_if.data_in = 8'hA5;
    cyc();
    b_if.wr_en = 1'b0;
    checks++;
    if ({b_if.empty, b_if.data_out} !== {1'b0, 8'hA5}) begin
      errors++; $display("FAIL fwft_show: got e=%b d=%h want e=0 d=a5", b_if.empty, b_if.data_out);
    end
    b_if.wr_en = 1'b1; b_if.data_in = 8'h5A;
    cyc();
    b_if.wr_en = 1'b0;
    checks++;
    if ({b_if.count, b_if.data_out} !== {5'd2, 8'hA5}) begin
      errors++; $display("FAIL fwft_hold: got c=%0d d=%h want c=2 d=a5", b_if.count, b_if.data_out);
    end
    b_if.rd_en = 1'b1;
    cyc();
    checks++;
    if ({b_if.count, b_if.data_out} !== {5'd1, 8'h5A}) begin
      errors++; $display("FAIL fwft_pop1: got c=%0d d=%h want c=1 d=5a", b_if.count, b_if.data_out);
    end
    cyc();
    b_if.rd_en = 1'b0;
    checks++;
    if ({b_if.empty, b_if.count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL fwft_pop2: got e=%b c=%0d want e=1 c=0", b_if.empty, b_if.count);
    end
  endtask

  task automatic test_flush_clr_rst();
    a_if.rd_en = 1'b1;
    cyc();
    a_if.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_if.wr_en = 1'b1; a_if.data_in = 8'h80 + 8'(i);
      cyc();
    end
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b1;
    cyc();
    checks++;
    if ({a_if.count, a_if.data_out} !== {5'd9, 8'h80}) begin
      errors++; $display("FAIL pre_flush: got c=%0d d=%h want c=9 d=80", a_if.count, a_if.data_out);
    end
    a_if.flush = 1'b1; a_if.wr_en = 1'b1; a_if.data_in = 8'hCC;
    cyc();
    a_idle();
    checks++;
    if ({a_if.count, a_if.empty, a_if.overflow, a_if.underflow, a_if.data_out} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 8'h80}) begin
      errors++; $display("FAIL flush: got c=%0d e=%b o=%b u=%b d=%h want c=0 e=1 o=0 u=1 d=80",
        a_if.count, a_if.empty, a_if.overflow, a_if.underflow, a_if.data_out);
    end
    a_if.wr_en = 1'b1; a_if.data_in = 8'h99;
    cyc();
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b1;
    cyc();
    a_if.rd_en = 1'b0;
    checks++;
    if ({a_if.count, a_if.data_out} !== {5'd0, 8'h99}) begin
      errors++; $display("FAIL post_flush: got c=%0d d=%h want c=0 d=99", a_if.count, a_if.data_out);
    end
    for (int i = 0; i < 17; i++) begin
      a_if.wr_en = 1'b1; a_if.data_in = 8'h40 + 8'(i);
      cyc();
    end
    a_if.wr_en = 1'b0;
    checks++;
    if ({a_if.overflow, a_if.underflow} !== 2'b11) begin
      errors++; $display("FAIL both_err: got %b want 11", {a_if.overflow, a_if.underflow});
    end
    a_if.clr_err = 1'b1;
    cyc();
    a_if.clr_err = 1'b0;
    checks++;
    if ({a_if.overflow, a_if.underflow} !== 2'b00) begin
      errors++; $display("FAIL clr_err: got %b want 00", {a_if.overflow, a_if.underflow});
    end
    a_if.rd_en = 1'b1;
    cyc(); cyc();
    checks++;
    if ({a_if.count, a_if.data_out} !== {5'd14, 8'h41}) begin
      errors++; $display("FAIL pre_rst: got c=%0d d=%h want c=14 d=41", a_if.count, a_if.data_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_if.count, a_if.empty, a_if.full, a_if.almost_empty, a_if.data_out} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL async_rst: got c=%0d e=%b f=%b ae=%b d=%h want c=0 e=1 f=0 ae=1 d=00",
        a_if.count, a_if.empty, a_if.full, a_if.almost_empty, a_if.data_out);
    end
    a_if.rd_en = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if ({a_if.count, a_if.underflow, a_if.overflow} !== {5'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL post_rst: got c=%0d u=%b o=%b want c=0 u=0 o=0",
        a_if.count, a_if.underflow, a_if.overflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_empty_simul();
    test_fwft();
    test_flush_clr_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
